// File: rtl/tick_timer_ctrl.sv
// Programmable one-shot/periodic tick timer with config handshake and start/pause/stop control.
// Optional prescaler is built when TIMER_PRESCALE_EN is defined.
module tick_timer_ctrl #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic             cfg_periodic,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StRun, StHold, StDone} state_e;

  state_e           state;
  logic [WIDTH-1:0] period;
  logic             periodic;
  logic             step_en;
  logic             wrap;

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("PRESCALE must be at least 1");
  end

  assign cfg_ready = (state == StIdle) || (state == StDone);
  assign wrap      = (count == period - WIDTH'(1));

`ifdef TIMER_PRESCALE_EN
  localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PsW-1:0] presc;
  assign step_en = (presc == PsW'(PRESCALE - 1));
`else
  assign step_en = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= StIdle;
      period   <= '0;
      periodic <= 1'b0;
      count    <= '0;
      tick     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef TIMER_PRESCALE_EN
      presc    <= '0;
`endif
    end else begin
      tick <= 1'b0;
      if (stop) begin
        state <= StIdle;
        count <= '0;
        busy  <= 1'b0;
        done  <= 1'b0;
`ifdef TIMER_PRESCALE_EN
        presc <= '0;
`endif
      end else if (cfg_valid && cfg_ready) begin
        period   <= cfg_period;
        periodic <= cfg_periodic;
        count    <= '0;
        done     <= 1'b0;
`ifdef TIMER_PRESCALE_EN
        presc    <= '0;
`endif
        // A start offered alongside the config runs with the new period.
        if (start && (cfg_period != '0)) begin
          state <= StRun;
          busy  <= 1'b1;
        end else begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      end else if (start && cfg_ready) begin
        if (period != '0) begin
          state <= StRun;
          count <= '0;
          busy  <= 1'b1;
          done  <= 1'b0;
`ifdef TIMER_PRESCALE_EN
          presc <= '0;
`endif
        end
      end else if ((state == StRun) || (state == StHold)) begin
        if (pause) begin
          state <= StHold;
        end else begin
          state <= StRun;
`ifdef TIMER_PRESCALE_EN
          presc <= step_en ? '0 : presc + PsW'(1);
`endif
          if (step_en) begin
            if (wrap) begin
              count <= '0;
              tick  <= 1'b1;
              if (!periodic) begin
                state <= StDone;
                done  <= 1'b1;
                busy  <= 1'b0;
              end
            end else begin
              count <= count + WIDTH'(1);
            end
          end
        end
      end
    end
  end

endmodule
